// File: rtl/decoder_pkg.sv
// Shared decode helpers and mode encodings for the registered select decoders.
package decoder_pkg;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_N_OUT = 2 ** MAX_SEL_W;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef logic [MAX_N_OUT-1:0] onehot_t;

  // Callers narrow the result to their own output count with a size cast.
  function automatic onehot_t onehot(input logic [MAX_SEL_W-1:0] idx);
    onehot_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: counts enabled cycles and flags the edge where the index should advance.
module scan_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tc_o
);

  logic [DIV_W-1:0] pcnt_q, pcnt_d;

  // >= rather than == so a lowered div forces an advance instead of a long count wrap.
  assign tc_o = en_i & ~clr_i & (pcnt_q >= div_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i)
      pcnt_d = '0;
    else if (en_i)
      pcnt_d = tc_o ? '0 : pcnt_q + DIV_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder with direct select or round-robin auto-scan; all outputs from flops.
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DIV_W      = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                mode_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic [DIV_W-1:0]    div_i,
  output logic [2**SEL_W-1:0] out_o,
  output logic [SEL_W-1:0]    idx_o,
  output logic                step_o,
  output logic                wrap_o
);

  localparam int N_OUT = 2 ** SEL_W;
  localparam logic [N_OUT-1:0] INACTIVE = ACTIVE_LOW ? {N_OUT{1'b1}} : '0;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             clr;
  logic             tc;

  assign clr = en_i & (mode_i == MODE_DIRECT);

  scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .clr_i (clr),
    .div_i (div_i),
    .tc_o  (tc)
  );

  always_comb begin
    idx_d  = idx_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (en_i) begin
      if (mode_i == MODE_DIRECT) begin
        idx_d = sel_i;
      end else if (tc) begin
        idx_d  = idx_q + SEL_W'(1);
        step_d = 1'b1;
        wrap_d = (idx_q == {SEL_W{1'b1}});
      end
    end
    // Decode the next index so out and idx update together on the same edge.
    out_d = en_i ? (N_OUT'(onehot(MAX_SEL_W'(idx_d))) ^ INACTIVE) : INACTIVE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      out_q  <= INACTIVE;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign out_o  = out_q;
  assign idx_o  = idx_q;
  assign step_o = step_q;
  assign wrap_o = wrap_q;

endmodule
